// File: rtl/stack_rpn_ctrl.sv
// RPN command sequencer driving an external byte stack through push/pop pulses.
// The controller keeps its own entry count so it can refuse commands that would
// overflow or underflow the stack before any pulse reaches it.
module stack_rpn_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned POP_LAT = 2,
    localparam int unsigned DW     = $clog2(DEPTH + 1),
    localparam int unsigned CW     = $clog2(POP_LAT + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [2:0]    i_cmd_op,
    input  logic [7:0]    i_cmd_data,
    input  logic          i_err_clr,
    output logic          o_stk_push,
    output logic          o_stk_pop,
    output logic [7:0]    o_stk_data_in,
    input  logic [7:0]    i_stk_data_out,
    input  logic          i_stk_error,
    output logic          o_res_valid,
    output logic [7:0]    o_res_data,
    output logic [DW-1:0] o_depth,
    output logic          o_err_flag
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_DUP  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StPush,
        StPopA,
        StWaitA,
        StPopB,
        StWaitB,
        StWb
    } state_e;

    state_e          r_state;
    logic [2:0]      r_op;
    logic [7:0]      r_a;
    logic [CW-1:0]   r_cnt;
    logic            r_dup2;
    logic            r_cmd_ready;
    logic            r_stk_push;
    logic            r_stk_pop;
    logic [7:0]      r_stk_data_in;
    logic            r_res_valid;
    logic [7:0]      r_res_data;
    logic [DW-1:0]   r_depth;
    logic            r_err_flag;

    logic            w_accept;
    logic            w_cmd_ok;
    logic            w_reject;
    logic [7:0]      w_alu;

    // Command acceptance and depth-based legality check on the accept cycle.
    always_comb begin
        w_accept = i_cmd_valid & r_cmd_ready;
        case (i_cmd_op)
            OP_NOP:  w_cmd_ok = 1'b1;
            OP_PUSH: w_cmd_ok = (r_depth < DW'(DEPTH));
            OP_POP:  w_cmd_ok = (r_depth >= DW'(1));
            OP_DUP:  w_cmd_ok = (r_depth >= DW'(1)) && (r_depth < DW'(DEPTH));
            default: w_cmd_ok = (r_depth >= DW'(2));
        endcase
        w_reject = w_accept & ~w_cmd_ok;
    end

    // ALU: B is the older operand arriving now on the stack read port, A was popped first.
    always_comb begin
        w_alu = 8'h00;
        case (r_op)
            OP_ADD:  w_alu = i_stk_data_out + r_a;
            OP_SUB:  w_alu = i_stk_data_out - r_a;
            OP_AND:  w_alu = i_stk_data_out & r_a;
            OP_XOR:  w_alu = i_stk_data_out ^ r_a;
            default: w_alu = 8'h00;
        endcase
    end

    // Sequencer FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_op          <= OP_NOP;
            r_a           <= 8'h00;
            r_cnt         <= '0;
            r_dup2        <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_stk_push    <= 1'b0;
            r_stk_pop     <= 1'b0;
            r_stk_data_in <= 8'h00;
            r_res_valid   <= 1'b0;
            r_res_data    <= 8'h00;
            r_depth       <= '0;
            r_err_flag    <= 1'b0;
        end else begin
            r_stk_push  <= 1'b0;
            r_stk_pop   <= 1'b0;
            r_res_valid <= 1'b0;

            // A set event in the same cycle as a clear keeps the flag high.
            if (w_reject || i_stk_error) begin
                r_err_flag <= 1'b1;
            end else if (i_err_clr) begin
                r_err_flag <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept && w_cmd_ok && (i_cmd_op != OP_NOP)) begin
                        r_op        <= i_cmd_op;
                        r_cmd_ready <= 1'b0;
                        if (i_cmd_op == OP_PUSH) begin
                            r_stk_push    <= 1'b1;
                            r_stk_data_in <= i_cmd_data;
                            r_depth       <= r_depth + DW'(1);
                            r_state       <= StPush;
                        end else begin
                            r_stk_pop <= 1'b1;
                            r_depth   <= r_depth - DW'(1);
                            r_state   <= StPopA;
                        end
                    end
                end
                StPush: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                StPopA: begin
                    r_cnt   <= CW'(POP_LAT - 1);
                    r_state <= StWaitA;
                end
                StWaitA: begin
                    if (r_cnt == '0) begin
                        r_a <= i_stk_data_out;
                        if (r_op == OP_POP) begin
                            r_res_valid <= 1'b1;
                            r_res_data  <= i_stk_data_out;
                            r_state     <= StWb;
                        end else if (r_op == OP_DUP) begin
                            r_stk_push    <= 1'b1;
                            r_stk_data_in <= i_stk_data_out;
                            r_res_valid   <= 1'b1;
                            r_res_data    <= i_stk_data_out;
                            r_depth       <= r_depth + DW'(1);
                            r_dup2        <= 1'b0;
                            r_state       <= StWb;
                        end else begin
                            r_stk_pop <= 1'b1;
                            r_depth   <= r_depth - DW'(1);
                            r_state   <= StPopB;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StPopB: begin
                    r_cnt   <= CW'(POP_LAT - 1);
                    r_state <= StWaitB;
                end
                StWaitB: begin
                    if (r_cnt == '0) begin
                        r_stk_push    <= 1'b1;
                        r_stk_data_in <= w_alu;
                        r_res_valid   <= 1'b1;
                        r_res_data    <= w_alu;
                        r_depth       <= r_depth + DW'(1);
                        r_state       <= StWb;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StWb: begin
                    // DUP spends a second WB cycle re-pushing the same byte.
                    if ((r_op == OP_DUP) && !r_dup2) begin
                        r_stk_push <= 1'b1;
                        r_depth    <= r_depth + DW'(1);
                        r_dup2     <= 1'b1;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_stk_push    = r_stk_push;
    assign o_stk_pop     = r_stk_pop;
    assign o_stk_data_in = r_stk_data_in;
    assign o_res_valid   = r_res_valid;
    assign o_res_data    = r_res_data;
    assign o_depth       = r_depth;
    assign o_err_flag    = r_err_flag;

endmodule

// File: tb/tb_stack_rpn_ctrl.sv
// Bench for stack_rpn_ctrl: a behavioural byte stack with read latency sits on the
// stack side, and a queue-based RPN model predicts results, depth, error and timing.
module tb_stack_rpn_ctrl;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned POP_LAT = 2;
    localparam int L = POP_LAT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       err_clr = 1'b0;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_data_in;
    logic [7:0] stk_data_out;
    logic       stk_error = 1'b0;
    logic       res_valid;
    logic [7:0] res_data;
    logic [4:0] depth;
    logic       err_flag;

    always #5 clk = ~clk;

    stack_rpn_ctrl #(
        .DEPTH   (DEPTH),
        .POP_LAT (POP_LAT)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_data     (cmd_data),
        .i_err_clr      (err_clr),
        .o_stk_push     (stk_push),
        .o_stk_pop      (stk_pop),
        .o_stk_data_in  (stk_data_in),
        .i_stk_data_out (stk_data_out),
        .i_stk_error    (stk_error),
        .o_res_valid    (res_valid),
        .o_res_data     (res_data),
        .o_depth        (depth),
        .o_err_flag     (err_flag)
    );

    // Behavioural stack: popped byte appears on the read port POP_LAT cycles after the pop.
    logic [7:0] mem [16];
    int         sp;
    logic [7:0] d1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp <= 0;
            d1 <= 8'h00;
            stk_data_out <= 8'h00;
        end else begin
            if (stk_push && sp < 16) begin
                mem[sp] <= stk_data_in;
                sp <= sp + 1;
            end else if (stk_pop && sp > 0) begin
                d1 <= mem[sp-1];
                sp <= sp - 1;
            end
            stk_data_out <= d1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, cycle numbers relative to the accept cycle of the current command.
    int         acc = 0;
    int         pop_q[$];
    int         push_q[$];
    logic [7:0] pushd_q[$];
    int         res_q[$];
    logic [7:0] resd_q[$];
    bit         both_seen = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (stk_pop) pop_q.push_back(cyc - acc);
            if (stk_push) begin
                push_q.push_back(cyc - acc);
                pushd_q.push_back(stk_data_in);
            end
            if (res_valid) begin
                res_q.push_back(cyc - acc);
                resd_q.push_back(res_data);
            end
            if (stk_push && stk_pop) both_seen = 1'b1;
        end
    end

    // Reference model.
    logic [7:0] mq[$];
    logic       m_err = 1'b0;
    logic [7:0] last_res;
    logic [7:0] last_push;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] dat);
        int n;
        int d;
        bit ok;
        int rdy_exp;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        int ep[$];
        int eu[$];
        logic [7:0] eud[$];
        int er[$];
        logic [7:0] erd[$];
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(cmd_ready), 32'd1);
        pop_q.delete(); push_q.delete(); pushd_q.delete(); res_q.delete(); resd_q.delete();
        acc = cyc;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = dat;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        d = mq.size();
        case (op)
            3'd0: ok = 1'b1;
            3'd1: ok = (d < DEPTH);
            3'd2: ok = (d >= 1);
            3'd7: ok = (d >= 1) && (d < DEPTH);
            default: ok = (d >= 2);
        endcase
        rdy_exp = 1;
        if (!ok) begin
            m_err = 1'b1;
        end else begin
            case (op)
                3'd0: ;
                3'd1: begin
                    eu.push_back(1); eud.push_back(dat); mq.push_back(dat); rdy_exp = 2;
                end
                3'd2: begin
                    a = mq.pop_back();
                    ep.push_back(1); er.push_back(2 + L); erd.push_back(a); rdy_exp = 3 + L;
                end
                3'd7: begin
                    a = mq[$];
                    mq.push_back(a);
                    ep.push_back(1);
                    eu.push_back(2 + L); eud.push_back(a);
                    eu.push_back(3 + L); eud.push_back(a);
                    er.push_back(2 + L); erd.push_back(a);
                    rdy_exp = 4 + L;
                end
                default: begin
                    a = mq.pop_back();
                    b = mq.pop_back();
                    case (op)
                        3'd3: r = b + a;
                        3'd4: r = b - a;
                        3'd5: r = b & a;
                        default: r = b ^ a;
                    endcase
                    mq.push_back(r);
                    ep.push_back(1); ep.push_back(2 + L);
                    eu.push_back(3 + 2 * L); eud.push_back(r);
                    er.push_back(3 + 2 * L); erd.push_back(r);
                    rdy_exp = 4 + 2 * L;
                end
            endcase
        end
        check("ready_cycle", 32'(n), 32'(rdy_exp));
        check("n_pop", 32'(pop_q.size()), 32'(ep.size()));
        for (int i = 0; i < ep.size() && i < pop_q.size(); i++)
            check("pop_cycle", 32'(pop_q[i]), 32'(ep[i]));
        check("n_push", 32'(push_q.size()), 32'(eu.size()));
        for (int i = 0; i < eu.size() && i < push_q.size(); i++) begin
            check("push_cycle", 32'(push_q[i]), 32'(eu[i]));
            check("push_data", 32'(pushd_q[i]), 32'(eud[i]));
        end
        check("n_res", 32'(res_q.size()), 32'(er.size()));
        for (int i = 0; i < er.size() && i < res_q.size(); i++) begin
            check("res_cycle", 32'(res_q[i]), 32'(er[i]));
            check("res_data", 32'(resd_q[i]), 32'(erd[i]));
        end
        check("depth", 32'(depth), 32'(mq.size()));
        check("err_flag", 32'(err_flag), 32'(m_err));
        last_res = (resd_q.size() > 0) ? resd_q[$] : 8'h00;
        last_push = (pushd_q.size() > 0) ? pushd_q[$] : 8'h00;
    endtask

    task automatic clr_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        check("err_clr", 32'(err_flag), 32'd0);
    endtask

    task automatic force_err(input bit with_clr);
        @(negedge clk);
        stk_error = 1'b1;
        err_clr = with_clr;
        @(negedge clk);
        stk_error = 1'b0;
        err_clr = 1'b0;
        m_err = 1'b1;
        check("stk_err_set", 32'(err_flag), 32'd1);
        @(negedge clk);
        check("stk_err_sticky", 32'(err_flag), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_push"}, 32'(stk_push), 32'd0);
        check({tag, "_pop"}, 32'(stk_pop), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_err"}, 32'(err_flag), 32'd0);
        check({tag, "_data_in"}, 32'(stk_data_in), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_depth"}, 32'(depth), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] op;
        // Power-on reset.
        #1 reset_n = 1'b0;
        #11;
        check_zero_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("por_ready", 32'(cmd_ready), 32'd1);
        check("por_depth", 32'(depth), 32'd0);

        // SUB ordering and POP readback.
        do_cmd(3'd1, 8'h05);
        do_cmd(3'd1, 8'h03);
        do_cmd(3'd4, 8'h00);
        check("sub_res", 32'(last_res), 32'h02);
        check("sub_depth", 32'(depth), 32'd1);
        do_cmd(3'd2, 8'h00);
        check("pop_res", 32'(last_res), 32'h02);
        check("pop_depth", 32'(depth), 32'd0);

        // ADD wraps modulo 256; XOR.
        do_cmd(3'd1, 8'hF0);
        do_cmd(3'd1, 8'h20);
        do_cmd(3'd3, 8'h00);
        check("add_res", 32'(last_res), 32'h10);
        check("add_push", 32'(last_push), 32'h10);
        do_cmd(3'd2, 8'h00);
        do_cmd(3'd1, 8'h0F);
        do_cmd(3'd1, 8'hFF);
        do_cmd(3'd6, 8'h00);
        check("xor_res", 32'(last_res), 32'hF0);
        do_cmd(3'd2, 8'h00);

        // Underflow reject on a binary op, then clear.
        do_cmd(3'd1, 8'h11);
        do_cmd(3'd3, 8'h00);
        check("rej_err", 32'(err_flag), 32'd1);
        check("rej_depth", 32'(depth), 32'd1);
        clr_err();
        do_cmd(3'd2, 8'h00);

        // Fill to capacity, then overflow reject.
        for (int i = 0; i < 16; i++) do_cmd(3'd1, 8'(i * 7 + 1));
        check("full_depth", 32'(depth), 32'd16);
        do_cmd(3'd1, 8'hEE);
        check("ovf_err", 32'(err_flag), 32'd1);
        check("ovf_no_push", 32'(push_q.size()), 32'd0);
        check("ovf_depth", 32'(depth), 32'd16);
        clr_err();
        for (int i = 0; i < 16; i++) do_cmd(3'd2, 8'h00);

        // DUP, then external stack error (alone and racing a clear).
        do_cmd(3'd1, 8'h7A);
        do_cmd(3'd7, 8'h00);
        check("dup_push", 32'(last_push), 32'h7A);
        check("dup_depth", 32'(depth), 32'd2);
        force_err(1'b0);
        clr_err();
        force_err(1'b1);
        clr_err();
        do_cmd(3'd2, 8'h00);
        do_cmd(3'd2, 8'h00);

        // Reset in the middle of an ADD while the pop pulse is high.
        do_cmd(3'd2, 8'h00);
        do_cmd(3'd1, 8'h33);
        do_cmd(3'd1, 8'h44);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_pop", 32'(stk_pop), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_zero_outputs("mid");
        mq.delete();
        m_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(cmd_ready), 32'd1);
        check("mid_depth", 32'(depth), 32'd0);

        // Random command stream against the model.
        for (int k = 0; k < 160; k++) begin
            if ($urandom_range(0, 7) == 0) clr_err();
            if ($urandom_range(0, 9) < 4) op = 3'd1;
            else op = 3'($urandom_range(0, 7));
            do_cmd(op, 8'($urandom));
        end

        check("push_pop_exclusive", 32'(both_seen), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
